// File: rtl/ysyx_23060025_rr_arbiter.sv
// ysyx_23060025_rr_arbiter
//   Round-robin request arbiter. It produces the select key for a shared-resource mux,
//   such as the memory/AXI port that IFU and LSU share. Once a requester wins, its grant
//   is locked until the responder pulses done. The next search then starts one past the
//   last winner.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req          [NR_REQ-1:0]  request vector, bit i = requester i
//   done         completion pulse from the granted transaction's responder
//   grant        [NR_REQ-1:0]  one-hot registered grant, zero when idle
//   grant_idx    [IDX_LEN-1:0] binary index of the granted requester, zero when idle
//   grant_valid  high while a grant is held (== |grant)
module ysyx_23060025_rr_arbiter #(
    parameter int NR_REQ  = 2,
    parameter int IDX_LEN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NR_REQ-1:0]  req,
    input  logic               done,
    output logic [NR_REQ-1:0]  grant,
    output logic [IDX_LEN-1:0] grant_idx,
    output logic               grant_valid
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_LEN-1:0] ptr_q, ptr_d;
    logic [IDX_LEN-1:0] idx_q, idx_d;
    logic [NR_REQ-1:0]  grant_q, grant_d;

    // Winner search, split into two ordered passes so the wrap needs no modulo adder.
    // The first pass looks at indices at or above ptr. The second pass looks at the
    // indices below ptr. Each pass keeps its lowest hit, and the upper pass wins.
    logic               hi_found, lo_found;
    logic [IDX_LEN-1:0] hi_idx, lo_idx, win_idx;
    logic [NR_REQ-1:0]  hi_oh, lo_oh, win_oh;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_oh    = '0;
        lo_oh    = '0;
        for (int c = 0; c < NR_REQ; c++) begin
            if (req[c] && (IDX_LEN'(c) >= ptr_q) && !hi_found) begin
                hi_found  = 1'b1;
                hi_idx    = IDX_LEN'(c);
                hi_oh[c]  = 1'b1;
            end
            if (req[c] && (IDX_LEN'(c) < ptr_q) && !lo_found) begin
                lo_found  = 1'b1;
                lo_idx    = IDX_LEN'(c);
                lo_oh[c]  = 1'b1;
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
        win_oh  = hi_found ? hi_oh  : lo_oh;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                // done is ignored here: there is no transaction to finish.
                if (hi_found || lo_found) begin
                    state_d = BUSY;
                    idx_d   = win_idx;
                    grant_d = win_oh;
                end
            end
            BUSY: begin
                // req is not looked at while BUSY, so the grant stays locked until done.
                if (done) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    grant_d = '0;
                    // Compare-based wrap, so it is also correct when NR_REQ is not a power of two.
                    ptr_d   = (idx_q == IDX_LEN'(NR_REQ - 1)) ? '0 : idx_q + IDX_LEN'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(grant_q))
                else $error("grant not one-hot or zero");
            assert (grant_valid == (|grant_q))
                else $error("grant_valid disagrees with grant");
            assert (!grant_valid || (grant_q == (NR_REQ'(1) << idx_q)))
                else $error("grant disagrees with grant_idx");
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_rr_arbiter.sv
// Bench for ysyx_23060025_rr_arbiter.
// Three instances (NR_REQ = 2, 3, 4) share one stimulus stream. Each instance sees the
// low NR_REQ bits of req. A behavioural model per instance tracks the rules directly:
// busy flag, pointer and winner, with a modular search from the pointer. The DUT outputs
// are compared with the model after every edge. Directed checks with fixed constants
// come first, followed by a randomized run.
module tb_ysyx_23060025_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [1:0] g2;  logic       i2;  logic v2;
    logic [2:0] g3;  logic [1:0] i3;  logic v3;
    logic [3:0] g4;  logic [1:0] i4;  logic v4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_23060025_rr_arbiter #(.NR_REQ(2), .IDX_LEN(1)) u_arb2 (
        .clk(clk), .rst_n(rst_n), .req(req[1:0]), .done(done),
        .grant(g2), .grant_idx(i2), .grant_valid(v2));
    ysyx_23060025_rr_arbiter #(.NR_REQ(3), .IDX_LEN(2)) u_arb3 (
        .clk(clk), .rst_n(rst_n), .req(req[2:0]), .done(done),
        .grant(g3), .grant_idx(i3), .grant_valid(v3));
    ysyx_23060025_rr_arbiter #(.NR_REQ(4), .IDX_LEN(2)) u_arb4 (
        .clk(clk), .rst_n(rst_n), .req(req[3:0]), .done(done),
        .grant(g4), .grant_idx(i4), .grant_valid(v4));

    // reference model state, one entry per instance
    int NS [3] = '{2, 3, 4};
    bit m_busy [3];
    int m_ptr  [3];
    int m_idx  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int j = 0; j < 3; j++) begin
            if (!rst_n) begin
                m_busy[j] = 0; m_ptr[j] = 0; m_idx[j] = 0;
            end else if (m_busy[j]) begin
                if (done) begin
                    m_busy[j] = 0;
                    m_ptr[j]  = (m_idx[j] + 1) % NS[j];
                end
            end else begin
                for (int k = 0; k < NS[j]; k++) begin
                    int c;
                    c = (m_ptr[j] + k) % NS[j];
                    if (!m_busy[j] && req[c]) begin
                        m_busy[j] = 1;
                        m_idx[j]  = c;
                    end
                end
            end
        end
    endtask

    task automatic cmp_model();
        logic [31:0] eg [3];
        logic [31:0] ei [3];
        for (int j = 0; j < 3; j++) begin
            eg[j] = m_busy[j] ? (32'd1 << m_idx[j]) : 32'd0;
            ei[j] = m_busy[j] ? 32'(m_idx[j]) : 32'd0;
        end
        chk("m2_grant", 32'(g2), eg[0]); chk("m2_idx", 32'(i2), ei[0]); chk("m2_vld", 32'(v2), 32'(m_busy[0]));
        chk("m3_grant", 32'(g3), eg[1]); chk("m3_idx", 32'(i3), ei[1]); chk("m3_vld", 32'(v3), 32'(m_busy[1]));
        chk("m4_grant", 32'(g4), eg[2]); chk("m4_idx", 32'(i4), ei[2]); chk("m4_vld", 32'(v4), 32'(m_busy[2]));
    endtask

    // One clock: update the model at the edge, then compare on the falling edge.
    // Callers change inputs after step returns, which keeps them away from the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0011; done = 1'b0;

        // reset with requests pending
        step(); chk("rst_grant0", 32'(g2), 0);
        step(); chk("rst_grant1", 32'(g2), 0); chk("rst_vld", 32'(v2), 0); chk("rst_idx", 32'(i2), 0);
        rst_n = 1'b1;
        step(); chk("post_rst_grant", 32'(g2), 32'b01); chk("post_rst_idx", 32'(i2), 0);
        done = 1'b1; step(); done = 1'b0;

        // single requester, then pointer wrap back to 0
        req = 4'b0010;
        step(); chk("single_grant", 32'(g2), 32'b10); chk("single_idx", 32'(i2), 1);
        done = 1'b1; step(); done = 1'b0; chk("single_release", 32'(g2), 0);
        req = 4'b0011;
        step(); chk("wrap_idx", 32'(i2), 0); chk("wrap_vld", 32'(v2), 1);
        done = 1'b1; step(); done = 1'b0; req = 4'b0000;

        // rotation on 4 requesters with one bubble between grants
        rst_n = 1'b0; step(); rst_n = 1'b1; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(); chk("rot_idx", 32'(i4), 32'(i % 4)); chk("rot_vld", 32'(v4), 1);
            step(); step();
            done = 1'b1; step(); done = 1'b0;
            chk("rot_bubble", 32'(v4), 0);
        end
        req = 4'b0000;

        // lock: grant held while req moves around
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b0100;
        step(); chk("lock_grant", 32'(g4), 32'b0100);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step(); chk("lock_hold", 32'(g4), 32'b0100);
        end
        done = 1'b1; step(); done = 1'b0; chk("lock_release", 32'(g4), 0);
        // spurious done while idle
        req = 4'b0000; done = 1'b1; step(); done = 1'b0; chk("spur_vld", 32'(v4), 0);
        step(); chk("spur_vld2", 32'(v4), 0);
        req = 4'b0001;
        step(); chk("lock_next_idx", 32'(i4), 0); chk("lock_next_vld", 32'(v4), 1);

        // skip search on 3 requesters from ptr=1
        done = 1'b1; step(); done = 1'b0; req = 4'b0000; step();
        req = 4'b0001;
        step(); chk("skip_wrap_idx", 32'(i3), 0);
        done = 1'b1; step(); done = 1'b0; req = 4'b0000;
        req = 4'b0101;
        step(); chk("skip_idx", 32'(i3), 2);
        done = 1'b1; step(); done = 1'b0; req = 4'b0000;

        // reset while busy, with done in the same cycle
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b0010;
        step(); chk("mid_idx", 32'(i2), 1);
        rst_n = 1'b0; done = 1'b1;
        step(); chk("mid_rst_grant", 32'(g2), 0); chk("mid_rst_vld", 32'(v2), 0); chk("mid_rst_idx", 32'(i2), 0);
        rst_n = 1'b1; done = 1'b0; req = 4'b0011;
        step(); chk("mid_after_idx", 32'(i2), 0); chk("mid_after_vld", 32'(v2), 1);

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            req   = 4'($urandom_range(0, 15));
            done  = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
